// File: rtl/cpu_pkg.sv
// Shared LEGv8 datapath constants and encodings for the execute stage.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_ORR   = 3'b101,
        ALU_EOR   = 3'b110,
        ALU_LSL   = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EX  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding selects and EX/MEM outputs of the execute stage.
// No valid/ready handshake: the pipeline advances every clock unless stalled or flushed.
interface ex_stage_if import cpu_pkg::*; ();

    logic              id_ex_valid;
    logic [DATA_W-1:0] id_ex_a;
    logic [DATA_W-1:0] id_ex_b;
    logic [DATA_W-1:0] id_ex_imm;
    logic              id_ex_alusrc;
    logic [2:0]        id_ex_aluop;
    logic              id_ex_setflags;
    logic              id_ex_regwrite;
    logic              id_ex_memread;
    logic              id_ex_memwrite;
    logic              id_ex_memtoreg;
    logic [REG_W-1:0]  id_ex_rw;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic [DATA_W-1:0] mem_wb_data;

    logic              ex_zero;
    logic [3:0]        flags;
    logic              EX_MEM_Valid;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemRead;
    logic              EX_MEM_MemWrite;
    logic              EX_MEM_MemToReg;
    logic [REG_W-1:0]  EX_MEM_Rw;
    logic [DATA_W-1:0] EX_MEM_Result;
    logic [DATA_W-1:0] EX_MEM_StoreData;

    modport master (
        output id_ex_valid, id_ex_a, id_ex_b, id_ex_imm, id_ex_alusrc, id_ex_aluop,
               id_ex_setflags, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_memtoreg, id_ex_rw, ForwardA, ForwardB, mem_wb_data,
        input  ex_zero, flags, EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead,
               EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_Rw, EX_MEM_Result, EX_MEM_StoreData
    );

    modport slave (
        input  id_ex_valid, id_ex_a, id_ex_b, id_ex_imm, id_ex_alusrc, id_ex_aluop,
               id_ex_setflags, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_memtoreg, id_ex_rw, ForwardA, ForwardB, mem_wb_data,
        output ex_zero, flags, EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead,
               EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_Rw, EX_MEM_Result, EX_MEM_StoreData
    );

endinterface

// File: rtl/alu64.sv
// Combinational 64-bit ALU producing the result and the NZCV it would set.
module alu64 import cpu_pkg::*; (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv
);

    logic [DATA_W:0] add_w;
    logic [DATA_W:0] sub_w;
    logic            c;
    logic            v;

    // Subtraction as a + ~b + 1, so the carry out is already NOT borrow.
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_PASSB: result = b;
            ALU_ADD: begin
                result = add_w[DATA_W-1:0];
                c      = add_w[DATA_W];
                v      = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result = sub_w[DATA_W-1:0];
                c      = sub_w[DATA_W];
                v      = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:   result = a & b;
            ALU_ORR:   result = a | b;
            ALU_EOR:   result = a ^ b;
            ALU_LSL:   result = a << b[5:0];
            default:   result = '0;
        endcase
        nzcv = {result[DATA_W-1], (result == '0), c, v};
    end

endmodule

// File: rtl/ex_stage.sv
// LEGv8 execute stage: forwarding operand muxes, ALU, NZCV register and EX/MEM register.
module ex_stage import cpu_pkg::*; (
    input logic       clk,
    input logic       reset,
    input logic       stall,
    input logic       flush,
    ex_stage_if.slave bus
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzcv;

    logic              ex_mem_valid;
    logic              ex_mem_regwrite;
    logic              ex_mem_memread;
    logic              ex_mem_memwrite;
    logic              ex_mem_memtoreg;
    logic [REG_W-1:0]  ex_mem_rw;
    logic [DATA_W-1:0] ex_mem_result;
    logic [DATA_W-1:0] ex_mem_storedata;
    logic [3:0]        flags_q;

    // The reserved select 11 falls through to the register-file value.
    always_comb begin
        case (fwd_sel_t'(bus.ForwardA))
            FWD_MEM: op_a = bus.mem_wb_data;
            FWD_EX:  op_a = ex_mem_result;
            default: op_a = bus.id_ex_a;
        endcase
        case (fwd_sel_t'(bus.ForwardB))
            FWD_MEM: fwd_b = bus.mem_wb_data;
            FWD_EX:  fwd_b = ex_mem_result;
            default: fwd_b = bus.id_ex_b;
        endcase
        op_b = bus.id_ex_alusrc ? bus.id_ex_imm : fwd_b;
    end

    alu64 u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (alu_op_t'(bus.id_ex_aluop)),
        .result (alu_result),
        .nzcv   (alu_nzcv)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_valid     <= 1'b0;
            ex_mem_regwrite  <= 1'b0;
            ex_mem_memread   <= 1'b0;
            ex_mem_memwrite  <= 1'b0;
            ex_mem_memtoreg  <= 1'b0;
            ex_mem_rw        <= '0;
            ex_mem_result    <= '0;
            ex_mem_storedata <= '0;
            flags_q          <= '0;
        end else if (flush) begin
            ex_mem_valid    <= 1'b0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            ex_mem_memtoreg <= 1'b0;
        end else if (!stall) begin
            ex_mem_valid     <= bus.id_ex_valid;
            // XZR writes are dropped here so the forwarding unit never matches X31.
            ex_mem_regwrite  <= bus.id_ex_regwrite & bus.id_ex_valid & (bus.id_ex_rw != XZR);
            ex_mem_memread   <= bus.id_ex_memread & bus.id_ex_valid;
            ex_mem_memwrite  <= bus.id_ex_memwrite & bus.id_ex_valid;
            ex_mem_memtoreg  <= bus.id_ex_memtoreg & bus.id_ex_valid;
            ex_mem_rw        <= bus.id_ex_rw;
            ex_mem_result    <= alu_result;
            ex_mem_storedata <= fwd_b;
            if (bus.id_ex_setflags && bus.id_ex_valid) begin
                flags_q <= alu_nzcv;
            end
        end
    end

    assign bus.ex_zero          = (fwd_b == '0);
    assign bus.flags            = flags_q;
    assign bus.EX_MEM_Valid     = ex_mem_valid;
    assign bus.EX_MEM_RegWrite  = ex_mem_regwrite;
    assign bus.EX_MEM_MemRead   = ex_mem_memread;
    assign bus.EX_MEM_MemWrite  = ex_mem_memwrite;
    assign bus.EX_MEM_MemToReg  = ex_mem_memtoreg;
    assign bus.EX_MEM_Rw        = ex_mem_rw;
    assign bus.EX_MEM_Result    = ex_mem_result;
    assign bus.EX_MEM_StoreData = ex_mem_storedata;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, stall/flush/reset sequences, random run vs model.
module tb_ex_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  logic stall;
  logic flush;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic        alusrc;
    logic [2:0]  op;
    logic        sf;
    logic        rwr;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [4:0]  rw;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [63:0] wb;
    logic        e_zero;
    logic        e_valid;
    logic        e_regw;
    logic        e_mw;
    logic [63:0] e_res;
    logic [63:0] e_store;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[17];

  // ---------------- model state ----------------
  logic        m_valid, m_regw, m_mr, m_mw, m_m2r;
  logic [4:0]  m_rw;
  logic [63:0] m_res, m_store;
  logic [3:0]  m_flags;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic alusrc, input logic [2:0] op,
                       input logic sf, input logic rwr, input logic mr, input logic mw,
                       input logic m2r, input logic [4:0] rw, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [63:0] wb);
    bus.id_ex_valid    = v;
    bus.id_ex_a        = a;
    bus.id_ex_b        = b;
    bus.id_ex_imm      = imm;
    bus.id_ex_alusrc   = alusrc;
    bus.id_ex_aluop    = op;
    bus.id_ex_setflags = sf;
    bus.id_ex_regwrite = rwr;
    bus.id_ex_memread  = mr;
    bus.id_ex_memwrite = mw;
    bus.id_ex_memtoreg = m2r;
    bus.id_ex_rw       = rw;
    bus.ForwardA       = fa;
    bus.ForwardB       = fb;
    bus.mem_wb_data    = wb;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.EX_MEM_Valid), 64'd0);
    check({tag, "_regw"},  64'(bus.EX_MEM_RegWrite), 64'd0);
    check({tag, "_mr"},    64'(bus.EX_MEM_MemRead), 64'd0);
    check({tag, "_mw"},    64'(bus.EX_MEM_MemWrite), 64'd0);
    check({tag, "_m2r"},   64'(bus.EX_MEM_MemToReg), 64'd0);
    check({tag, "_rw"},    64'(bus.EX_MEM_Rw), 64'd0);
    check({tag, "_res"},   bus.EX_MEM_Result, 64'd0);
    check({tag, "_store"}, bus.EX_MEM_StoreData, 64'd0);
    check({tag, "_flags"}, 64'(bus.flags), 64'd0);
  endtask

  // Reference ALU from arithmetic definitions: exact signed sums, unsigned compares.
  function automatic void ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                                  output logic [63:0] r, output logic [3:0] f);
    logic signed [65:0] sa, sb, exact;
    logic c, v;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        r = a + b;
        c = (r < a);
        exact = sa + sb;
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        exact = sa - sb;
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      3'b111: r = a << b[5:0];
      default: r = 64'd0;
    endcase
    f = {r[63], (r == 64'd0), c, v};
  endfunction

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_valid = 1'b0; m_regw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
    m_rw = 5'd0; m_res = 64'd0; m_store = 64'd0; m_flags = 4'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rnd_a, rnd_b, rnd_imm, rnd_wb, opa, fwdb, opb, r;
    logic [3:0]  f;
    logic [2:0]  rnd_op;
    logic [1:0]  rnd_fa, rnd_fb;
    logic [4:0]  rnd_rw;
    logic        rnd_v, rnd_src, rnd_sf, rnd_rwr, rnd_mr, rnd_mw, rnd_m2r;

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 64'd0);

    //              v     a                      b                      imm     src   op         sf    rwr   mr    mw    m2r   rw     fa     fb     wb      zero  val   regw  mw    res                    store                  flags
    vecs[0]  = '{1'b1, 64'h8,                 64'h8,                 64'h0,  1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h10,                64'h8,                 4'b0000};
    vecs[1]  = '{1'b1, 64'h0,                 64'h6,                 64'h0,  1'b0, ALU_SUB,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2,  2'b10, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'hA,                 64'h6,                 4'b0000};
    vecs[2]  = '{1'b1, 64'h3,                 64'h0,                 64'h0,  1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  2'b00, 2'b01, 64'h7, 1'b0, 1'b1, 1'b1, 1'b0, 64'hA,                 64'h7,                 4'b0000};
    vecs[3]  = '{1'b1, 64'h3,                 64'h0,                 64'h1,  1'b1, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  2'b00, 2'b01, 64'h7, 1'b0, 1'b1, 1'b1, 1'b0, 64'h4,                 64'h7,                 4'b0000};
    vecs[4]  = '{1'b1, 64'h5,                 64'h5,                 64'h0,  1'b0, ALU_SUB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4,  2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,                 64'h5,                 4'b0110};
    vecs[5]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,               64'h0,  1'b0, ALU_ADD,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1,               4'b1001};
    vecs[6]  = '{1'b1, 64'h1,                 64'h1,                 64'h0,  1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6,  2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h2,                 64'h1,                 4'b1001};
    vecs[7]  = '{1'b1, 64'h4,                 64'h5,                 64'h0,  1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h9,                 64'h5,                 4'b1001};
    vecs[8]  = '{1'b0, 64'hF0,                64'h0F,                64'h0,  1'b0, ALU_ORR,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFF,                64'h0F,                4'b1001};
    vecs[9]  = '{1'b1, 64'h2,                 64'h0,                 64'h0,  1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  2'b00, 2'b11, 64'h5, 1'b1, 1'b1, 1'b1, 1'b0, 64'h2,                 64'h0,                 4'b1001};
    vecs[10] = '{1'b1, 64'h1,                 64'h4,                 64'h0,  1'b0, ALU_LSL,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9,  2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h10,                64'h4,                 4'b1001};
    vecs[11] = '{1'b1, 64'hFF,                64'h0F,                64'h0,  1'b0, ALU_AND,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0F,                64'h0F,                4'b0000};
    vecs[12] = '{1'b1, 64'hFF,                64'h0F,                64'h0,  1'b0, ALU_EOR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hF0,                64'h0F,                4'b0000};
    vecs[13] = '{1'b1, 64'hFF,                64'h0F,                64'h0,  1'b0, 3'b001,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 64'h0F,                4'b0000};
    vecs[14] = '{1'b1, 64'h3,                 64'h5,                 64'h0,  1'b0, ALU_SUB,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5,               4'b1000};
    vecs[15] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1,               64'h0,  1'b0, ALU_SUB,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,               4'b0011};
    vecs[16] = '{1'b1, 64'h0,                 64'h0,                 64'h10, 1'b1, ALU_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13, 2'b10, 2'b00, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_000F, 64'h0,               4'b1001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].alusrc, vecs[i].op,
            vecs[i].sf, vecs[i].rwr, vecs[i].mr, vecs[i].mw, vecs[i].m2r, vecs[i].rw,
            vecs[i].fa, vecs[i].fb, vecs[i].wb);
      #1;
      check($sformatf("vec%0d_zero", i), 64'(bus.ex_zero), 64'(vecs[i].e_zero));
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(bus.EX_MEM_Valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_regw", i), 64'(bus.EX_MEM_RegWrite), 64'(vecs[i].e_regw));
      check($sformatf("vec%0d_mw", i), 64'(bus.EX_MEM_MemWrite), 64'(vecs[i].e_mw));
      check($sformatf("vec%0d_rw", i), 64'(bus.EX_MEM_Rw), 64'(vecs[i].rw));
      check($sformatf("vec%0d_res", i), bus.EX_MEM_Result, vecs[i].e_res);
      check($sformatf("vec%0d_store", i), bus.EX_MEM_StoreData, vecs[i].e_store);
      check($sformatf("vec%0d_flags", i), 64'(bus.flags), 64'(vecs[i].e_flags));
    end

    // Stall holds everything, flush clears controls only
    drive(1'b1, 64'h11, 64'h22, 64'h0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 2'b00, 2'b00, 64'h0);
    cycle();
    check("hold_load_res", bus.EX_MEM_Result, 64'h33);
    check("hold_load_mw", 64'(bus.EX_MEM_MemWrite), 64'd1);
    drive(1'b1, 64'h5, 64'h5, 64'h0, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 2'b00, 2'b00, 64'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("stall%0d_res", k), bus.EX_MEM_Result, 64'h33);
      check($sformatf("stall%0d_rw", k), 64'(bus.EX_MEM_Rw), 64'd3);
      check($sformatf("stall%0d_valid", k), 64'(bus.EX_MEM_Valid), 64'd1);
      check($sformatf("stall%0d_mw", k), 64'(bus.EX_MEM_MemWrite), 64'd1);
      check($sformatf("stall%0d_flags", k), 64'(bus.flags), 64'b1001);
    end
    flush = 1'b1;
    cycle();
    check("stflush_valid", 64'(bus.EX_MEM_Valid), 64'd0);
    check("stflush_regw", 64'(bus.EX_MEM_RegWrite), 64'd0);
    check("stflush_mw", 64'(bus.EX_MEM_MemWrite), 64'd0);
    check("stflush_res", bus.EX_MEM_Result, 64'h33);
    stall = 1'b0;
    cycle();
    check("flush_subs_flags", 64'(bus.flags), 64'b1001);
    check("flush_subs_valid", 64'(bus.EX_MEM_Valid), 64'd0);
    check("flush_subs_res", bus.EX_MEM_Result, 64'h33);
    flush = 1'b0;
    cycle();
    check("after_flush_flags", 64'(bus.flags), 64'b0110);
    check("after_flush_regw", 64'(bus.EX_MEM_RegWrite), 64'd1);

    // Asynchronous reset in the middle of a stall, then a normal first cycle
    stall = 1'b1;
    cycle();
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1;
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b1, 64'h2, 64'h3, 64'h0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 2'b00, 2'b00, 64'h0);
    cycle();
    check("post_reset_res", bus.EX_MEM_Result, 64'h5);
    check("post_reset_regw", 64'(bus.EX_MEM_RegWrite), 64'd1);
    check("post_reset_valid", 64'(bus.EX_MEM_Valid), 64'd1);
    check("post_reset_flags", 64'(bus.flags), 64'd0);

    // Random run against the reference model
    reset_pulse();
    for (int n = 0; n < 400; n++) begin
      rnd_a   = {$urandom, $urandom};
      rnd_b   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      rnd_imm = 64'($urandom_range(0, 4095));
      rnd_wb  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rnd_a = 64'h7FFF_FFFF_FFFF_FFFF + 64'($urandom_range(0, 2));
      rnd_op  = 3'($urandom_range(0, 7));
      rnd_fa  = 2'($urandom_range(0, 3));
      rnd_fb  = 2'($urandom_range(0, 3));
      rnd_rw  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      rnd_v   = ($urandom_range(0, 5) != 0);
      rnd_src = 1'($urandom_range(0, 1));
      rnd_sf  = 1'($urandom_range(0, 1));
      rnd_rwr = 1'($urandom_range(0, 1));
      rnd_mr  = 1'($urandom_range(0, 1));
      rnd_mw  = 1'($urandom_range(0, 1));
      rnd_m2r = 1'($urandom_range(0, 1));
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      drive(rnd_v, rnd_a, rnd_b, rnd_imm, rnd_src, rnd_op, rnd_sf, rnd_rwr, rnd_mr, rnd_mw,
            rnd_m2r, rnd_rw, rnd_fa, rnd_fb, rnd_wb);

      opa  = (rnd_fa == 2'd1) ? rnd_wb : (rnd_fa == 2'd2) ? m_res : rnd_a;
      fwdb = (rnd_fb == 2'd1) ? rnd_wb : (rnd_fb == 2'd2) ? m_res : rnd_b;
      opb  = rnd_src ? rnd_imm : fwdb;
      ref_alu(opa, opb, rnd_op, r, f);
      #1;
      check("rnd_zero", 64'(bus.ex_zero), 64'(fwdb == 64'd0));

      if (flush) begin
        m_valid = 1'b0; m_regw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
      end else if (!stall) begin
        m_valid = rnd_v;
        m_regw  = rnd_rwr && rnd_v && (rnd_rw != 5'd31);
        m_mr    = rnd_mr && rnd_v;
        m_mw    = rnd_mw && rnd_v;
        m_m2r   = rnd_m2r && rnd_v;
        m_rw    = rnd_rw;
        m_res   = r;
        m_store = fwdb;
        if (rnd_sf && rnd_v) m_flags = f;
      end

      cycle();
      check("rnd_valid", 64'(bus.EX_MEM_Valid), 64'(m_valid));
      check("rnd_regw", 64'(bus.EX_MEM_RegWrite), 64'(m_regw));
      check("rnd_mr", 64'(bus.EX_MEM_MemRead), 64'(m_mr));
      check("rnd_mw", 64'(bus.EX_MEM_MemWrite), 64'(m_mw));
      check("rnd_m2r", 64'(bus.EX_MEM_MemToReg), 64'(m_m2r));
      check("rnd_rw", 64'(bus.EX_MEM_Rw), 64'(m_rw));
      check("rnd_res", bus.EX_MEM_Result, m_res);
      check("rnd_store", bus.EX_MEM_StoreData, m_store);
      check("rnd_flags", 64'(bus.flags), 64'(m_flags));
    end
    stall = 1'b0;
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
